// File: rtl/qformat_pkg.sv
// Shared fixed-point format defaults and the dot-product sequencer state type.
// DEF_DATA_W/DEF_FRAC_W describe signed Q1.7 operands and results.
// DEF_ACC_W is chosen so a full-length run of full-scale products cannot wrap.
package qformat_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_FRAC_W = 7;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_ACC_W  = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } qdot_state_t;

endpackage

// File: rtl/qdot_sequencer_if.sv
// Handshake bundle between a dot-product client and qdot_sequencer.
//   master (client)    : drives start/len, operand stream, out_ready
//   slave  (sequencer) : drives in_ready, out_valid/out_data/out_sat, busy
interface qdot_sequencer_if #(
    parameter int DATA_W = qformat_pkg::DEF_DATA_W,
    parameter int LEN_W  = qformat_pkg::DEF_LEN_W
);
    logic                     start;
    logic        [LEN_W-1:0]  len;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;
    logic                     busy;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/qformat_requant.sv
// Combinational requantiser: wide signed accumulator (FRAC_W*2 fractional
// bits) -> DATA_W signed result with FRAC_W fractional bits.
// Rounds half-up (add half an output LSB, then arithmetic shift) and
// saturates to the DATA_W signed range.
//   acc : signed accumulator input
//   res : rounded, saturated result
//   sat : high when res was clamped
module qformat_requant
    import qformat_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] res,
    output logic                     sat
);
    // One extra bit so adding the rounding constant cannot overflow.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(1) << (FRAC_W - 1);
    localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

    logic signed [SUM_W-1:0] rounded;
    logic signed [SUM_W-1:0] shifted;

    assign rounded = {acc[ACC_W-1], acc} + HALF;
    assign shifted = rounded >>> FRAC_W;

    always_comb begin
        res = shifted[DATA_W-1:0];
        sat = 1'b0;
        if (shifted > MAX_V) begin
            res = MAX_V[DATA_W-1:0];
            sat = 1'b1;
        end else if (shifted < MIN_V) begin
            res = MIN_V[DATA_W-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/qdot_sequencer.sv
// Signed Q1.7 dot-product sequencer. A start with len operand pairs
// accumulates in_a*in_b over len accepted beats, requantises the sum and
// presents it on out_data until the consumer accepts it.
//   clk   : sole clock
//   reset : synchronous, active-high
//   bus   : slave side of qdot_sequencer_if (start/len, operand stream,
//           result handshake, busy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; acc cleared and len loaded on start
// S_RUN   | accepting operand pairs, counter counts beats down to 0
// S_ROUND | one cycle: requantised acc registered into out_data/out_sat
// S_DONE  | result valid and held until out_valid&out_ready
module qdot_sequencer
    import qformat_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    qdot_sequencer_if.slave   bus
);
    qdot_state_t state, state_nx;

    logic signed [ACC_W-1:0]    acc;
    logic        [LEN_W-1:0]    cnt;
    logic signed [DATA_W-1:0]   res_q;
    logic                       sat_q;
    logic signed [DATA_W-1:0]   rq_res;
    logic                       rq_sat;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic                       beat;
    logic                       last_beat;

    // Full-width signed product from a single multiplier.
    assign a_ext    = {{DATA_W{bus.in_a[DATA_W-1]}}, bus.in_a};
    assign b_ext    = {{DATA_W{bus.in_b[DATA_W-1]}}, bus.in_b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    assign beat      = (state == S_RUN) && bus.in_valid;
    assign last_beat = beat && (cnt == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nx = (bus.len != '0) ? S_RUN : S_ROUND;
            end
            S_RUN: begin
                if (last_beat) state_nx = S_ROUND;
            end
            S_ROUND: state_nx = S_DONE;
            S_DONE: begin
                if (bus.out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
            sat_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc <= '0;
                        cnt <= bus.len;
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                S_ROUND: begin
                    res_q <= rq_res;
                    sat_q <= rq_sat;
                end
                default: ;
            endcase
        end
    end

    qformat_requant #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_requant (
        .acc (acc),
        .res (rq_res),
        .sat (rq_sat)
    );

    assign bus.in_ready  = (state == S_RUN);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_data  = res_q;
    assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_qdot_sequencer.sv
// Self-checking bench for qdot_sequencer: directed corner cases plus
// randomized runs compared against a plain-arithmetic reference model.
module tb_qdot_sequencer;
    import qformat_pkg::*;

    logic clk;
    logic reset;

    qdot_sequencer_if bus ();

    qdot_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] va [0:255];
    logic [7:0] vb [0:255];

    // Exact dot product, round half-up to 1/128, clamp to [-128,127].
    function automatic void model(input int n, output logic [7:0] d, output logic s);
        longint sum;
        longint t;
        longint q;
        sum = 0;
        for (int i = 0; i < n; i++)
            sum += longint'($signed(va[i])) * longint'($signed(vb[i]));
        t = sum + 64;
        if (t >= 0) q = t / 128;
        else        q = -((-t + 127) / 128);
        s = 1'b0;
        if (q > 127)  begin q = 127;  s = 1'b1; end
        if (q < -128) begin q = -128; s = 1'b1; end
        d = q[7:0];
    endfunction

    // Runs one dot product of the first n entries of va/vb. lat counts the
    // edges from the last handshake (or start when n==0) up to the first
    // edge after which out_valid is seen high.
    task automatic do_run(input int n, input bit gaps, input bit noise, input bit ack,
                          output int lat, output logic [7:0] d, output logic s,
                          output bit saw_rdy, output bit to);
        int  i;
        int  guard;
        bit  hs;
        to = 1'b0;
        saw_rdy = 1'b0;
        d = '0;
        s = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = n[7:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        i = 0;
        guard = 0;
        while (i < n && !to) begin
            @(negedge clk);
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_a  = va[i];
            bus.in_b  = vb[i];
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.len   = 8'($urandom_range(0, 255));
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hs) i++;
            guard++;
            if (guard > 4000) to = 1'b1;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) saw_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) to = 1'b1;
        if (bus.in_ready) saw_rdy = 1'b1;
        d = bus.out_data;
        s = bus.out_sat;
        if (ack) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%0b exp=0", bus.out_sat); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] exp_d [0:4];
        logic       exp_s [0:4];
        int         lens  [0:4];
        logic [7:0] pa    [0:4];
        logic [7:0] pb    [0:4];
        int lat; logic [7:0] d; logic s; bit rdy; bit to;
        lens = '{1, 1, 1, 4, 2};
        pa   = '{8'h40, 8'h01, 8'h01, 8'h7F, 8'h80};
        pb   = '{8'h40, 8'h40, 8'h3F, 8'h7F, 8'h7F};
        exp_d = '{8'h20, 8'h01, 8'h00, 8'h7F, 8'h80};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < lens[c]; k++) begin
                va[k] = pa[c];
                vb[k] = pb[c];
            end
            do_run(lens[c], 1'b0, 1'b0, 1'b1, lat, d, s, rdy, to);
            checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout got=timeout exp=result", c); end
            checks++; if (d !== exp_d[c]) begin errors++; $display("FAIL dir%0d_data got=%h exp=%h", c, d, exp_d[c]); end
            checks++; if (s !== exp_s[c]) begin errors++; $display("FAIL dir%0d_sat got=%0b exp=%0b", c, s, exp_s[c]); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=2", c, lat); end
        end
    endtask

    task automatic test_len_zero();
        int lat; logic [7:0] d; logic s; bit rdy; bit to;
        do_run(0, 1'b0, 1'b0, 1'b1, lat, d, s, rdy, to);
        checks++; if (to) begin errors++; $display("FAIL len0_timeout got=timeout exp=result"); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL len0_data got=%h exp=00", d); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL len0_sat got=%0b exp=0", s); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL len0_latency got=%0d exp=2", lat); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL len0_in_ready got=%0b exp=0", rdy); end
    endtask

    task automatic test_start_in_run();
        int lat; logic [7:0] d; logic s; bit rdy; bit to;
        logic [7:0] ed; logic es;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) begin
                va[k] = 8'($urandom);
                vb[k] = 8'($urandom);
            end
            model(6, ed, es);
            do_run(6, 1'b1, 1'b1, 1'b1, lat, d, s, rdy, to);
            checks++; if (to) begin errors++; $display("FAIL startrun%0d_timeout got=timeout exp=result", r); end
            checks++; if (d !== ed || s !== es) begin errors++; $display("FAIL startrun%0d_result got=%h/%0b exp=%h/%0b", r, d, s, ed, es); end
        end
    endtask

    task automatic test_hold();
        int lat; logic [7:0] d; logic s; bit rdy; bit to;
        logic [7:0] ed; logic es;
        va[0] = 8'h30; vb[0] = 8'hC0;
        va[1] = 8'($urandom); vb[1] = 8'($urandom);
        model(2, ed, es);
        do_run(2, 1'b0, 1'b0, 1'b0, lat, d, s, rdy, to);
        checks++; if (to) begin errors++; $display("FAIL hold_timeout got=timeout exp=result"); end
        checks++; if (d !== ed || s !== es) begin errors++; $display("FAIL hold_result got=%h/%0b exp=%h/%0b", d, s, ed, es); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_out_valid got=%0b exp=1", k, bus.out_valid); end
            checks++; if (bus.out_data !== ed || bus.out_sat !== es) begin errors++; $display("FAIL hold%0d_outputs got=%h/%0b exp=%h/%0b", k, bus.out_data, bus.out_sat, ed, es); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got=%0b exp=0", k, bus.in_ready); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold%0d_busy got=%0b exp=1", k, bus.busy); end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = 8'd1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ack_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ack_out_valid got=%0b exp=0", bus.out_valid); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ack_start_ignored got=busy%0b exp=busy0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] d; logic s; bit rdy; bit to;
        for (int k = 0; k < 4; k++) begin
            va[k] = 8'h7F;
            vb[k] = 8'h7F;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a = va[k];
            bus.in_b = vb[k];
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrun_in_ready got=%0b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrun_out_valid got=%0b exp=0", bus.out_valid); end
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        va[0] = 8'h40; vb[0] = 8'h40;
        do_run(1, 1'b0, 1'b0, 1'b1, lat, d, s, rdy, to);
        checks++; if (to) begin errors++; $display("FAIL after_reset_timeout got=timeout exp=result"); end
        checks++; if (d !== 8'h20 || s !== 1'b0) begin errors++; $display("FAIL after_reset_result got=%h/%0b exp=20/0", d, s); end

        va[0] = 8'h7F; vb[0] = 8'h7F;
        do_run(1, 1'b0, 1'b0, 1'b0, lat, d, s, rdy, to);
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL middone_state got=valid%0b/busy%0b exp=valid0/busy0", bus.out_valid, bus.busy); end
        checks++; if (bus.out_data !== 8'h00 || bus.out_sat !== 1'b0) begin errors++; $display("FAIL middone_outputs got=%h/%0b exp=00/0", bus.out_data, bus.out_sat); end
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat; logic [7:0] d; logic s; bit rdy; bit to;
        logic [7:0] ed; logic es;
        int n;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 3))
                    0: begin va[k] = 8'h80; vb[k] = 8'($urandom_range(0, 1) ? 8'h80 : 8'h7F); end
                    1: begin va[k] = 8'($urandom_range(0, 4)); vb[k] = 8'($urandom_range(0, 80)); end
                    default: begin va[k] = 8'($urandom); vb[k] = 8'($urandom); end
                endcase
            end
            model(n, ed, es);
            do_run(n, 1'($urandom_range(0, 1)), 1'b0, 1'b1, lat, d, s, rdy, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got=timeout exp=result", r); end
            checks++; if (d !== ed || s !== es) begin errors++; $display("FAIL rand%0d_result len=%0d got=%h/%0b exp=%h/%0b", r, n, d, s, ed, es); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=2", r, lat); end
        end
        // Longest run, most positive product every beat: must saturate, not wrap.
        for (int k = 0; k < 255; k++) begin
            va[k] = 8'h80;
            vb[k] = 8'h80;
        end
        model(255, ed, es);
        do_run(255, 1'b0, 1'b0, 1'b1, lat, d, s, rdy, to);
        checks++; if (to) begin errors++; $display("FAIL fullscale_timeout got=timeout exp=result"); end
        checks++; if (d !== ed || s !== es) begin errors++; $display("FAIL fullscale_result got=%h/%0b exp=%h/%0b", d, s, ed, es); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_len_zero();
        test_start_in_run();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
